// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch requester (read-only) and an operand requester (read/write).
// Each access runs IDLE -> BUSY (MEM_LAT cycles) -> RESP (valid pulse).
// Optional build macro MEM_PORT_ARBITER_RR_EN swaps the fixed operand
// priority plus starvation counter for round-robin conflict resolution.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  input  logic                  i_o_req,
  input  logic                  i_o_we,
  input  logic [ADDR_WIDTH-1:0] i_o_addr,
  input  logic [DATA_WIDTH-1:0] i_o_wdata,
  output logic                  o_f_gnt,
  output logic                  o_f_valid,
  output logic                  o_o_gnt,
  output logic                  o_o_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_ren,
  output logic                  o_mem_wen,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_O} owner_t;

  state_t                state, state_nx;
  owner_t                owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            cnt;
  logic                  first_q;
  logic                  any_req;
  logic                  pick_f;

  assign any_req = i_f_req | i_o_req;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_f;

  // On a conflict the requester that did not win last time gets the port
  assign pick_f = i_f_req & (~i_o_req | ~last_f);

  // Remember the most recent winner; resets to fetch so operand wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_f <= 1'b1;
    end else if (state == S_IDLE && any_req) begin
      last_f <= pick_f;
    end
  end
`else
  logic [3:0] starve_cnt;

  // Operand has priority until fetch has lost STARVE_LIMIT times in a row
  assign pick_f = i_f_req & (~i_o_req | (starve_cnt == 4'(STARVE_LIMIT)));

  // Count operand wins that made a waiting fetch lose; saturate at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE && any_req) begin
      if (pick_f) begin
        starve_cnt <= '0;
      end else if (i_f_req && starve_cnt != 4'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = S_BUSY;
      S_BUSY:  if (cnt == '0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Latch the winning request, count the memory cycle, capture read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner   <= OWN_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      first_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner   <= pick_f ? OWN_F : OWN_O;
            addr_q  <= pick_f ? i_f_addr : i_o_addr;
            we_q    <= ~pick_f & i_o_we;
            wdata_q <= pick_f ? '0 : i_o_wdata;
            cnt     <= 3'(MEM_LAT - 1);
            first_q <= 1'b1;
          end
        end
        S_BUSY: begin
          first_q <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 3'd1;
          end else if (!we_q) begin
            rdata_q <= i_mem_rdata;
          end
        end
        S_RESP: begin
          owner <= OWN_NONE;
        end
        default: begin
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Handshake pulses and memory-side drive, all decoded from state
  always_comb begin
    o_f_gnt     = 1'b0;
    o_o_gnt     = 1'b0;
    o_f_valid   = 1'b0;
    o_o_valid   = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_rdata     = rdata_q;
    o_busy      = (state != S_IDLE);
    case (state)
      S_BUSY: begin
        o_f_gnt     = first_q & (owner == OWN_F);
        o_o_gnt     = first_q & (owner == OWN_O);
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        o_mem_ren   = ~we_q;
        o_mem_wen   = we_q & first_q;
      end
      S_RESP: begin
        o_f_valid = (owner == OWN_F);
        o_o_valid = (owner == OWN_O);
      end
      default: begin
        o_f_gnt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters.
  - Fetch path: IP-driven, read-only.
  - Operand path: decoder-driven, read or write.
- Sits between the decoder/IP logic and the memory macro, and replaces direct enable wiring.
- Sequences each access through a fixed-latency memory cycle.
- Returns read data with a one-cycle valid pulse per requester.

Parameters:
- DATA_WIDTH, 8, width of data words; matches `DATA_WIDTH.
- ADDR_WIDTH, 8, width of memory address.
- MEM_LAT, 2, memory read latency in cycles; legal range 1..7.
- STARVE_LIMIT, 3, consecutive operand wins while fetch waits before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_f_req  in  1  fetch request; held until o_f_gnt
- i_f_addr  in  ADDR_WIDTH  fetch address
- i_o_req  in  1  operand request; held until o_o_gnt
- i_o_we  in  1  operand access type; 1=write, 0=read
- i_o_addr  in  ADDR_WIDTH  operand address
- i_o_wdata  in  DATA_WIDTH  operand write data
- o_f_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_f_valid  out  1  fetch data valid on o_rdata (1-cycle pulse)
- o_o_gnt  out  1  operand request accepted (1-cycle pulse)
- o_o_valid  out  1  operand access complete (1-cycle pulse); o_rdata valid if read
- o_rdata  out  DATA_WIDTH  returned read data, held until the next read completes
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_ren  out  1  memory read enable
- o_mem_wen  out  1  memory write enable
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- o_busy  out  1  arbiter not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0, state=IDLE, starve_cnt=0, latency counter=0, owner=none.
- While rst_n=0 the arbiter aborts any access in flight. No gnt or valid pulse is emitted for that access.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample i_f_req and i_o_req at each edge.
  - If any request is present, go to BUSY, latch owner, latch address/we/wdata, and load the counter with MEM_LAT-1.
- Arbitration:
  - Only i_o_req set: operand wins.
  - Only i_f_req set: fetch wins.
  - Both set: operand wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - +1 when operand is granted while i_f_req=1 (saturates at STARVE_LIMIT).
  - Cleared to 0 when fetch is granted.
  - Unchanged otherwise.
- Grant pulse: o_f_gnt or o_o_gnt is high for exactly the first BUSY cycle.
- The requester must drop or replace its request after gnt. A request still high in IDLE is treated as a new request.
- BUSY:
  - Memory signals are driven from the latched values.
  - o_mem_ren=1 for all MEM_LAT cycles on reads.
  - o_mem_wen=1 only in the first BUSY cycle on writes; ren=0 on writes.
  - The counter decrements each cycle.
  - When counter==0: on reads, capture i_mem_rdata into o_rdata; go to RESP.
- RESP: the owner's valid pulse is high for one cycle, memory enables are 0, then go to IDLE.
- Throughput: one access per MEM_LAT+2 cycles.
- Latency: request sampled at edge k gives gnt in cycle k+1 and valid in cycle k+1+MEM_LAT.
- o_mem_ren and o_mem_wen are never high simultaneously; both are 0 in IDLE and RESP.
- Writes leave o_rdata unchanged.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a conflict the requester not granted last wins. The last-winner flag resets to "fetch", so the first conflict goes to operand. starve_cnt logic is removed and STARVE_LIMIT is ignored.
- Undefined: fixed operand priority with starvation counter as described above.

Test Plan:
- Fetch-only read: i_f_req=1, i_f_addr=0x10, mem returns 0xA5, MEM_LAT=2.
  - o_f_gnt in cycle 1; o_mem_ren high cycles 1-2 with addr 0x10.
  - o_f_valid in cycle 3 with o_rdata=0xA5.
- Operand write: i_o_req=1, we=1, addr=0x20, wdata=0x3C.
  - o_mem_wen=1 for exactly one cycle with addr 0x20 and wdata 0x3C; o_mem_ren=0.
  - o_o_valid two cycles later; o_rdata unchanged.
- Simultaneous requests, both held continuously, STARVE_LIMIT=3.
  - Grant order is O,O,O,F,O,O,O,F.
  - starve_cnt is 0 after each fetch grant.
- Back-to-back operand reads at addresses 0x01 and 0x02.
  - Accesses are spaced MEM_LAT+2=4 cycles apart.
  - No overlap of mem enables; each o_o_valid carries the matching data.
- Reset mid-BUSY: rst_n=0 in the second BUSY cycle.
  - Next cycle all outputs are 0, state IDLE, no valid pulse, o_rdata=0.
- With MEM_PORT_ARBITER_RR_EN and both requests held: grants alternate O,F,O,F.
